cnt_sequencer: RTL

Controller that sequences the team's up/down counter datapath. It accepts configuration and run commands over a valid/ready command port and drives the counter's enable, direction and load strobes. It uses a programmable prescaler and a terminal-count limit, and signals completion. It sits between the Tiny Tapeout pin decode (ui_in/uio_in) and the counter register inside the top-level tt_um wrapper.

---
 rtl/cnt_seq_pkg.sv | 27 ++
 rtl/cnt_prescaler.sv | 28 ++
 rtl/cnt_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: opcodes and FSM states for the counter sequencer.
// Optional periodic reload: CNT_SEQ_AUTO_RELOAD_EN.
package cnt_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_LOAD       = 3'd1,
    OP_SET_LIMIT  = 3'd2,
    OP_SET_PRESC  = 3'd3,
    OP_START_UP   = 3'd4,
    OP_START_DOWN = 3'd5,
    OP_STOP       = 3'd6,
    OP_CLEAR      = 3'd7
  } op_e;

  // Encodings double as the state_o values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_start(op_e op);
    return (op == OP_START_UP) || (op == OP_START_DOWN);
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// cnt_prescaler: divide counter, ticks every (presc+1) clocks while run.
// Part of cnt_sequencer (optional CNT_SEQ_AUTO_RELOAD_EN lives in the top).
module cnt_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == presc);

  always_comb begin
    cnt_d = cnt_q + PRESC_W'(1);
    if (clr || !run || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cnt_sequencer.sv
// cnt_sequencer: command-driven FSM that strobes the up/down counter.
// Define CNT_SEQ_AUTO_RELOAD_EN for periodic reload at terminal count.
module cnt_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             busy,
  output logic             done,
  output logic             cmd_err,
  output logic [1:0]       state_o
);

  state_e             state_q;
  logic [WIDTH-1:0]   limit_q;
  logic [PRESC_W-1:0] presc_q;
  logic               en_q, up_q, load_q;
  logic               done_q, err_q;
  logic [WIDTH-1:0]   lval_q;
`ifdef CNT_SEQ_AUTO_RELOAD_EN
  logic [WIDTH-1:0]   ldval_q;
`endif

  op_e              op;
  logic             acc, run, tick, clr, tick_go, term;
  logic [WIDTH-1:0] eff;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = !load_q;
  assign acc       = cmd_valid && cmd_ready;
  assign run       = (state_q == ST_RUN);

  assign clr = acc && ((is_start(op) && !run) ||
                       (op == OP_SET_PRESC && run));

  cnt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .run   (run),
    .presc (presc_q),
    .tick  (tick)
  );

  // cnt_value lags a strobe by a cycle; judge the value it is about to hold.
  always_comb begin
    eff = cnt_value;
    if (load_q)    eff = lval_q;
    else if (en_q) eff = up_q ? cnt_value + WIDTH'(1)
                              : cnt_value - WIDTH'(1);
  end

  assign term    = up_q ? (eff == limit_q) : (eff == '0);
  assign tick_go = tick &&
    !(acc && (op == OP_STOP || op == OP_CLEAR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      limit_q <= '1;
      presc_q <= '0;
      en_q    <= 1'b0;
      up_q    <= 1'b0;
      load_q  <= 1'b0;
      lval_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CNT_SEQ_AUTO_RELOAD_EN
      ldval_q <= '0;
`endif
    end else begin
      en_q   <= 1'b0;
      load_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (acc) begin
        unique case (op)
          OP_NOP: begin
          end
          OP_LOAD: begin
            if (run) err_q <= 1'b1;
            else begin
              load_q  <= 1'b1;
              lval_q  <= cmd_data;
              state_q <= ST_IDLE;
`ifdef CNT_SEQ_AUTO_RELOAD_EN
              ldval_q <= cmd_data;
`endif
            end
          end
          OP_SET_LIMIT: limit_q <= cmd_data;
          OP_SET_PRESC: presc_q <= cmd_data[PRESC_W-1:0];
          OP_START_UP, OP_START_DOWN: begin
            if (run) err_q <= 1'b1;
            else begin
              up_q    <= (op == OP_START_UP);
              state_q <= ST_RUN;
            end
          end
          OP_STOP: begin
            if (run) state_q <= ST_IDLE;
            else     err_q   <= 1'b1;
          end
          OP_CLEAR: begin
            load_q  <= 1'b1;
            lval_q  <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
      if (tick_go) begin
        if (!term) en_q <= 1'b1;
        else begin
          done_q <= 1'b1;
`ifdef CNT_SEQ_AUTO_RELOAD_EN
          load_q <= 1'b1;
          lval_q <= ldval_q;
`else
          state_q <= ST_DONE;
`endif
        end
      end
    end
  end

  assign cnt_en       = en_q;
  assign cnt_up       = up_q;
  assign cnt_load     = load_q;
  assign cnt_load_val = lval_q;
  assign busy         = run;
  assign done         = done_q;
  assign cmd_err      = err_q;
  assign state_o      = state_q;

endmodule
